cam_access_arbiter: RTL and testbench
=====================================

Name: cam_access_arbiter

Overview:
- Shares the 16 CAM subarrays between two requesters: the store path (single-subarray writes) and the search path (broadcast key compare across all 16 subarrays).
- Arbitrates between them, sequences each access as ISSUE then WAIT for the subarray acknowledge, and returns done/match results to the winner.
- A watchdog releases the array if the acknowledge never arrives.
- Sits between the store controller / search front-end and the subarray bank.

Parameters:
- TIMEOUT_CYC, 15: maximum WAIT cycles before abort; valid range 1..255.
- NUM_SUB, 16: subarray count. Fixed at 16; width of chip_enable and match vectors.

Ports:
- rst  input  1  asynchronous reset, active-low
- CLK  input  1  clock, rising edge
- wr_req  input  1  store request; held high until wr_done
- wr_addr  input  10  store address
- wr_data  input  16  store data
- wr_sub  input  4  target subarray index
- wr_gnt  output  1  store access in progress (ISSUE through done)
- wr_done  output  1  one-cycle pulse: store access finished
- srch_req  input  1  search request; held high until srch_done
- srch_key  input  16  search key
- srch_gnt  output  1  search access in progress
- srch_done  output  1  one-cycle pulse: search finished
- srch_match  output  16  registered per-subarray match result, valid from srch_done onward
- array_ack  input  1  subarray bank acknowledge
- array_match  input  16  subarray match lines, sampled on array_ack
- chip_enable  output  16  subarray selects
- arr_addr  output  10  address to bank
- arr_data  output  16  data or key to bank
- arr_mode  output  1  0 = write, 1 = search
- arr_valid  output  1  one-cycle command strobe
- timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: async, active-low. All outputs 0, state IDLE, timeout counter 0, fairness pointer points to store. A reset mid-access aborts the access with no done pulse.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any request is high at the rising edge, latch the winner's operands and go to ISSUE. No request: stay in IDLE.
- Arbitration without the optional feature: wr_req has fixed priority over srch_req.
- ISSUE (exactly 1 cycle):
  - gnt for the winner = 1, arr_valid = 1.
  - Write: chip_enable = 1 << wr_sub, arr_mode = 0, arr_addr/arr_data = latched wr_addr/wr_data.
  - Search: chip_enable = 16'hFFFF, arr_mode = 1, arr_addr = 0, arr_data = latched key.
  - Next state: WAIT, with the counter cleared.
- WAIT:
  - chip_enable, arr_mode, arr_addr, arr_data and gnt are held; arr_valid = 0.
  - The counter increments every cycle.
  - array_ack = 1: go to DONE. For a search, array_match is latched into srch_match.
  - Counter reaches TIMEOUT_CYC with no ack: go to DONE with an abort flag. srch_match is forced to 0.
  - If ack arrives in the same cycle the counter reaches TIMEOUT_CYC, ack wins and there is no error.
- DONE (1 cycle):
  - chip_enable = 0, gnt = 0.
  - wr_done or srch_done = 1 for the winner; timeout_err = 1 if aborted.
  - Next state: IDLE.
- Requester rule: deassert req in the cycle after done. A req still high in IDLE is treated as a new request.
- array_ack outside WAIT is ignored.
- Latency: req sampled at edge k; ISSUE during k..k+1; WAIT from k+1. An ack sampled at edge m gives done high during m..m+1. Minimum request-to-done is 3 cycles.
- The operands on the requester ports may change after ISSUE; the latched values are used.
- The counter is 8 bits and saturates, never wraps.

Optional Feature:
- Macro: CAM_ARB_FAIR_EN.
- Defined: round-robin arbitration. A 1-bit pointer flips to the other requester after every completed DONE (including aborts). When both requests are high, the requester the pointer designates wins.
- Undefined: fixed store priority; the pointer does not exist.

Decomposition:
- Package cam_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}
  - MODE_WRITE = 1'b0, MODE_SEARCH = 1'b1
  - SEARCH_ALL_CE = 16'hFFFF
  - NUM_SUB = 16
- Sub-module cam_arb_watchdog: the saturating 8-bit counter with clear and enable inputs and a hit output (count == TIMEOUT_CYC).
- The FSM, arbitration and datapath registers stay in the top module.

Test Plan:
- Write only:
  - Stimulus: wr_req with wr_sub=5, wr_addr=10'h0A3, wr_data=16'hBEEF; ack 2 cycles into WAIT.
  - Required: one arr_valid pulse, chip_enable=16'h0020, arr_mode=0, wr_done 5 cycles after req, timeout_err=0.
- Search only:
  - Stimulus: srch_key=16'h1234; array_match=16'h8001 with ack.
  - Required: chip_enable=16'hFFFF, arr_mode=1, srch_done pulse, srch_match=16'h8001.
- Contention:
  - Stimulus: wr_req and srch_req raised together, each held until its done.
  - Required without CAM_ARB_FAIR_EN: store granted first, then search.
  - Required with CAM_ARB_FAIR_EN over 4 back-to-back accesses: grants alternate W, S, W, S.
- Timeout:
  - Stimulus: search with no ack, TIMEOUT_CYC=15.
  - Required: timeout_err and srch_done pulse together; srch_match=0; next request is served normally.
- Ack at the limit: ack in the same cycle the counter reaches 15 → done with timeout_err=0.
- Reset mid-WAIT:
  - Stimulus: rst low for 1 cycle during WAIT.
  - Required: outputs immediately 0, no done pulse, IDLE after release; a late array_ack is ignored.

Source files
------------

// File: rtl/cam_access_arbiter_pkg.sv
// cam_pkg: shared types and constants for the CAM access arbiter.
// Imported by the interface, the arbiter and its testbench.
package cam_pkg;
  localparam int NUM_SUB = 16;
  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_SEARCH = 1'b1;
  localparam logic [NUM_SUB-1:0] SEARCH_ALL_CE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;
endpackage

// File: rtl/cam_access_arbiter_if.sv
// cam_access_arbiter_if: requester and subarray-bank signals.
// slave = arbiter side, master = requesters + bank side.
interface cam_access_arbiter_if;
  import cam_pkg::*;

  logic               wr_req;
  logic [9:0]         wr_addr;
  logic [15:0]        wr_data;
  logic [3:0]         wr_sub;
  logic               wr_gnt;
  logic               wr_done;
  logic               srch_req;
  logic [15:0]        srch_key;
  logic               srch_gnt;
  logic               srch_done;
  logic [NUM_SUB-1:0] srch_match;
  logic               array_ack;
  logic [NUM_SUB-1:0] array_match;
  logic [NUM_SUB-1:0] chip_enable;
  logic [9:0]         arr_addr;
  logic [15:0]        arr_data;
  logic               arr_mode;
  logic               arr_valid;
  logic               timeout_err;

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_sub,
    input  srch_req, srch_key,
    input  array_ack, array_match,
    output wr_gnt, wr_done,
    output srch_gnt, srch_done, srch_match,
    output chip_enable, arr_addr, arr_data,
    output arr_mode, arr_valid, timeout_err
  );

  modport master (
    output wr_req, wr_addr, wr_data, wr_sub,
    output srch_req, srch_key,
    output array_ack, array_match,
    input  wr_gnt, wr_done,
    input  srch_gnt, srch_done, srch_match,
    input  chip_enable, arr_addr, arr_data,
    input  arr_mode, arr_valid, timeout_err
  );
endinterface

// File: rtl/cam_access_arbiter_watchdog.sv
// cam_arb_watchdog: saturating 8-bit WAIT counter.
// hit_o flags count == TIMEOUT_CYC.
module cam_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic CLK,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  logic [7:0] cnt_q, cnt_d;

  // clear wins; otherwise count up and stick at 255
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // counter register
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign hit_o = (cnt_q == 8'(TIMEOUT_CYC));
endmodule

// File: rtl/cam_access_arbiter.sv
// cam_access_arbiter: shares the CAM subarrays between store and search.
// Define CAM_ARB_FAIR_EN for round-robin instead of store priority.
module cam_access_arbiter
  import cam_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input logic CLK,
  input logic rst,
  cam_access_arbiter_if.slave bus
);
  arb_state_t state_q, state_d;
  logic               srch_q, srch_d;
  logic [9:0]         addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic [3:0]         sub_q, sub_d;
  logic               abort_q, abort_d;
  logic [NUM_SUB-1:0] match_q, match_d;
  logic               wd_clr, wd_en, wd_hit;
  logic               pick_srch;
  logic               in_acc;

`ifdef CAM_ARB_FAIR_EN
  logic ptr_q, ptr_d;

  // pointer moves to the other side after every finished access
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == DONE) ptr_d = ~ptr_q;
  end

  // fairness pointer register, 0 = store
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

  assign pick_srch = bus.srch_req && (!bus.wr_req || ptr_q);
`else
  assign pick_srch = bus.srch_req && !bus.wr_req;
`endif

  cam_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .CLK  (CLK),
    .rst  (rst),
    .clr_i(wd_clr),
    .en_i (wd_en),
    .hit_o(wd_hit)
  );

  // access sequencing and operand latching
  always_comb begin
    state_d = state_q;
    srch_d  = srch_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sub_d   = sub_q;
    abort_d = abort_q;
    match_d = match_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_req || bus.srch_req) begin
          state_d = ISSUE;
          srch_d  = pick_srch;
          abort_d = 1'b0;
          if (pick_srch) begin
            addr_d = '0;
            data_d = bus.srch_key;
            sub_d  = '0;
          end else begin
            addr_d = bus.wr_addr;
            data_d = bus.wr_data;
            sub_d  = bus.wr_sub;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wd_clr  = 1'b1;
      end
      WAIT: begin
        wd_en = 1'b1;
        if (bus.array_ack) begin
          state_d = DONE;
          if (srch_q) match_d = bus.array_match;
        end else if (wd_hit) begin
          state_d = DONE;
          abort_d = 1'b1;
          if (srch_q) match_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      srch_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sub_q   <= '0;
      abort_q <= 1'b0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      srch_q  <= srch_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sub_q   <= sub_d;
      abort_q <= abort_d;
      match_q <= match_d;
    end
  end

  assign in_acc = (state_q == ISSUE) || (state_q == WAIT);

  assign bus.wr_gnt      = in_acc && !srch_q;
  assign bus.srch_gnt    = in_acc && srch_q;
  assign bus.arr_valid   = (state_q == ISSUE);
  assign bus.arr_mode    = in_acc ? (srch_q ? MODE_SEARCH : MODE_WRITE)
                                  : 1'b0;
  assign bus.arr_addr    = in_acc ? addr_q : '0;
  assign bus.arr_data    = in_acc ? data_q : '0;
  assign bus.chip_enable = !in_acc ? '0
                         : srch_q  ? SEARCH_ALL_CE
                                   : (NUM_SUB'(1) << sub_q);
  assign bus.wr_done     = (state_q == DONE) && !srch_q;
  assign bus.srch_done   = (state_q == DONE) && srch_q;
  assign bus.timeout_err = (state_q == DONE) && abort_q;
  assign bus.srch_match  = match_q;
endmodule

// File: tb/tb_cam_access_arbiter.sv
// tb_cam_access_arbiter: random + directed scoreboard bench.
// Expected accesses come from a transaction-level model.
module tb_cam_access_arbiter;
  import cam_pkg::*;

  localparam int TO = 15;

  logic CLK = 1'b0;
  logic rst = 1'b0;
  logic bank_ack = 1'b0;
  logic late_ack = 1'b0;
  logic [15:0] bank_match = 16'h0;

  cam_access_arbiter_if bus();

  cam_access_arbiter #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  assign bus.array_ack   = bank_ack | late_ack;
  assign bus.array_match = bank_match;

  typedef struct {
    bit          srch;
    logic [15:0] ce;
    logic [9:0]  addr;
    logic [15:0] data;
    int          lat;
    bit          to;
    logic [15:0] match;
  } exp_t;

  typedef struct {
    int          dly;
    logic [15:0] match;
    bit          stray;
  } ack_t;

  exp_t exp_q[$];
  ack_t ack_q[$];
  int errs = 0;
  int checks = 0;
  bit ptr = 1'b0;
  logic [15:0] last_match = 16'h0;
  int mcyc = 0;
  int mt0 = 0;
  bit mhas = 1'b0;
  exp_t mcur;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // One access as the model sees it: who, what it drives, how it ends.
  function automatic void model_acc(input bit s, input logic [3:0] sub,
                                    input logic [9:0] a,
                                    input logic [15:0] d, input int dly,
                                    input logic [15:0] m);
    exp_t e;
    ack_t k;
    e.srch = s;
    e.to   = (dly > TO);
    e.lat  = (e.to ? TO : dly) + 2;
    if (s) begin
      e.ce   = 16'hFFFF;
      e.addr = 10'h0;
      e.data = d;
      last_match = e.to ? 16'h0 : m;
    end else begin
      e.ce   = 16'd1 << sub;
      e.addr = a;
      e.data = d;
    end
    e.match = last_match;
    ptr     = ~ptr;
    k.dly   = dly;
    k.match = m;
    k.stray = 1'($urandom_range(0, 1));
    exp_q.push_back(e);
    ack_q.push_back(k);
  endfunction

  // Subarray bank: acks after the planned delay, never for timeouts.
  initial begin
    ack_t k;
    forever begin
      @(negedge CLK);
      if (rst && bus.arr_valid) begin
        checks++;
        if (ack_q.size() == 0) begin
          errs++;
          $display("FAIL bank_issue: got issue want none");
        end else begin
          k = ack_q.pop_front();
          if (k.dly <= TO) begin
            repeat (k.dly + 1) @(negedge CLK);
            bank_ack   = 1'b1;
            bank_match = k.match;
            @(negedge CLK);
            if (k.stray) @(negedge CLK);
            bank_ack   = 1'b0;
            bank_match = 16'($urandom);
          end
        end
      end
    end
  end

  // Monitor: compares every issue, wait and done cycle to the queue.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      mcyc++;
      if (!rst) begin
        mhas = 1'b0;
      end else if (bus.arr_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL mon_issue: got issue want none");
        end else begin
          mcur = exp_q.pop_front();
          mhas = 1'b1;
          mt0  = mcyc;
          chk("issue_gnt", {bus.wr_gnt, bus.srch_gnt},
              mcur.srch ? 2'b01 : 2'b10);
          chk("issue_ce", bus.chip_enable, mcur.ce);
          chk("issue_mode", bus.arr_mode, mcur.srch);
          chk("issue_addr", bus.arr_addr, mcur.addr);
          chk("issue_data", bus.arr_data, mcur.data);
        end
      end else if (bus.wr_done || bus.srch_done) begin
        checks++;
        if (!mhas) begin
          errs++;
          $display("FAIL mon_done: got done want none");
        end else begin
          mhas = 1'b0;
          chk("done_kind", {bus.wr_done, bus.srch_done},
              mcur.srch ? 2'b01 : 2'b10);
          chk("latency", mcyc - mt0, mcur.lat);
          chk("timeout_err", bus.timeout_err, mcur.to);
          chk("done_ce", bus.chip_enable, 16'h0);
          if (mcur.srch) chk("srch_match", bus.srch_match, mcur.match);
        end
      end else if (mhas) begin
        chk("wait_ce", bus.chip_enable, mcur.ce);
        chk("wait_mode", bus.arr_mode, mcur.srch);
        chk("wait_gnt", {bus.wr_gnt, bus.srch_gnt},
            mcur.srch ? 2'b01 : 2'b10);
        chk("wait_addr", bus.arr_addr, mcur.addr);
        chk("wait_data", bus.arr_data, mcur.data);
      end else begin
        chk("idle_out", {bus.chip_enable, bus.timeout_err,
                         bus.wr_gnt, bus.srch_gnt}, 19'h0);
      end
    end
  end

  task automatic run_scn(input bit dw, input bit ds,
                         input logic [3:0] sub, input logic [9:0] a,
                         input logic [15:0] wd, input logic [15:0] key,
                         input int wdly, input int sdly,
                         input logic [15:0] sm);
    bit s_first;
    bit pw, ps;
    int n;
`ifdef CAM_ARB_FAIR_EN
    s_first = ds && (!dw || ptr);
`else
    s_first = ds && !dw;
`endif
    if (s_first) begin
      model_acc(1'b1, 4'h0, 10'h0, key, sdly, sm);
      if (dw) model_acc(1'b0, sub, a, wd, wdly, 16'h0);
    end else begin
      if (dw) model_acc(1'b0, sub, a, wd, wdly, 16'h0);
      if (ds) model_acc(1'b1, 4'h0, 10'h0, key, sdly, sm);
    end
    @(negedge CLK);
    bus.wr_sub   = sub;
    bus.wr_addr  = a;
    bus.wr_data  = wd;
    bus.srch_key = key;
    bus.wr_req   = dw;
    bus.srch_req = ds;
    pw = dw;
    ps = ds;
    n  = 0;
    while ((pw || ps) && n < 200) begin
      @(negedge CLK);
      n++;
      if (bus.wr_done) begin
        bus.wr_req = 1'b0;
        pw = 1'b0;
      end
      if (bus.srch_done) begin
        bus.srch_req = 1'b0;
        ps = 1'b0;
      end
      if (bus.wr_gnt) begin
        bus.wr_addr = 10'($urandom);
        bus.wr_data = 16'($urandom);
        bus.wr_sub  = 4'($urandom);
      end
      if (bus.srch_gnt) bus.srch_key = 16'($urandom);
    end
    chk("scn_finished", {pw, ps}, 2'b00);
    bus.wr_req   = 1'b0;
    bus.srch_req = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge CLK);
  endtask

  function automatic int rnd_dly();
    if ($urandom_range(0, 9) == 0) return $urandom_range(16, 30);
    return $urandom_range(0, 15);
  endfunction

  initial begin
    int r;
    int n;
    bus.wr_req   = 1'b0;
    bus.srch_req = 1'b0;
    bus.wr_addr  = 10'h0;
    bus.wr_data  = 16'h0;
    bus.wr_sub   = 4'h0;
    bus.srch_key = 16'h0;

    repeat (3) @(negedge CLK);
    chk("rst_ce", bus.chip_enable, 16'h0);
    chk("rst_ctl", {bus.wr_gnt, bus.wr_done, bus.srch_gnt,
                    bus.srch_done, bus.arr_valid, bus.arr_mode,
                    bus.timeout_err}, 7'h0);
    chk("rst_bus", {bus.arr_addr, bus.arr_data}, 26'h0);
    chk("rst_match", bus.srch_match, 16'h0);
    rst = 1'b1;
    repeat (2) @(negedge CLK);

    run_scn(1, 0, 4'd5, 10'h0A3, 16'hBEEF, 16'h0, 2, 0, 16'h0);
    run_scn(0, 1, 4'd0, 10'h0, 16'h0, 16'h1234, 0, 0, 16'h8001);
    run_scn(1, 1, 4'd9, 10'h3FF, 16'hA5A5, 16'h5A5A, 1, 3, 16'h00F0);
    run_scn(1, 1, 4'd0, 10'h001, 16'h0001, 16'hFFFF, 0, 0, 16'h0F00);
    run_scn(0, 1, 4'd0, 10'h0, 16'h0, 16'hCAFE, 0, 99, 16'hFFFF);
    run_scn(1, 0, 4'd15, 10'h155, 16'h1111, 16'h0, 0, 0, 16'h0);
    run_scn(0, 1, 4'd0, 10'h0, 16'h0, 16'h7777, 0, TO, 16'h4242);
    run_scn(1, 0, 4'd3, 10'h2AA, 16'h2222, 16'h0, TO + 1, 0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      run_scn(r != 1, r != 0, 4'($urandom), 10'($urandom),
              16'($urandom), 16'($urandom), rnd_dly(), rnd_dly(),
              16'($urandom));
    end

    model_acc(1'b1, 4'h0, 10'h0, 16'hDEAD, 99, 16'h0);
    @(negedge CLK);
    bus.srch_key = 16'hDEAD;
    bus.srch_req = 1'b1;
    n = 0;
    while (!bus.srch_gnt && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_test_gnt", bus.srch_gnt, 1'b1);
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    #1;
    chk("midrst_ce", bus.chip_enable, 16'h0);
    chk("midrst_ctl", {bus.wr_gnt, bus.srch_gnt, bus.wr_done,
                       bus.srch_done, bus.arr_valid, bus.timeout_err},
        6'h0);
    chk("midrst_match", bus.srch_match, 16'h0);
    bus.srch_req = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    ptr = 1'b0;
    last_match = 16'h0;
    late_ack = 1'b1;
    repeat (2) @(negedge CLK);
    late_ack = 1'b0;
    chk("late_ack_done", {bus.wr_done, bus.srch_done,
                          bus.timeout_err}, 3'h0);
    chk("late_ack_ce", bus.chip_enable, 16'h0);
    repeat (2) @(negedge CLK);

    run_scn(1, 1, 4'd7, 10'h0C3, 16'h3C3C, 16'h0BAD, 4, 2, 16'h1001);
    repeat (4) @(negedge CLK);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("ack_q_empty", ack_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
